// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTL unit: applies at most STEP positions per clock,
// with valid/ready handshakes on the operand and result sides.
module iter_shifter #(
   parameter int N    = 32,
   parameter int STEP = 4,
   localparam int SW  = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    op,
   input  logic [SW-1:0] shamt,
   input  logic [N-1:0]  din,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  dout,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [SW-1:0] STEPW = SW'(STEP);
   localparam logic [SW:0]   NW    = (SW+1)'(N);

   state_t        state;
   logic [N-1:0]  work;
   logic [SW-1:0] rem;
   logic [1:0]    op_q;
   logic          sign_q;

   logic [SW-1:0] step_amt;
   logic [SW:0]   rot_back;
   logic [N-1:0]  shifted;

   // One step of the selected shift; the last step uses whatever remains.
   always_comb begin
      step_amt = (rem > STEPW) ? STEPW : rem;
      rot_back = NW - {1'b0, step_amt};
      shifted  = work;
      case (op_q)
         2'b00:   shifted = work << step_amt;
         2'b01:   shifted = work >> step_amt;
         2'b10:   shifted = (work >> step_amt) | (sign_q ? ~({N{1'b1}} >> step_amt) : '0);
         default: shifted = (work << step_amt) | (work >> rot_back);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         work   <= '0;
         rem    <= '0;
         op_q   <= 2'b00;
         sign_q <= 1'b0;
         dout   <= '0;
      end else if (flush) begin
         state <= IDLE;
         rem   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work   <= din;
                  op_q   <= op;
                  rem    <= shamt;
                  sign_q <= din[N-1];
                  state  <= BUSY;
               end
            end
            BUSY: begin
               work <= shifted;
               if (rem > STEPW) begin
                  rem <= rem - STEPW;
               end else begin
                  rem   <= '0;
                  dout  <= shifted;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter (N=32, STEP=4) with hand-computed results and latencies.
module tb_iter_shifter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [4:0]  shamt = '0;
   logic [31:0] din = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] dout;
   logic        busy;

   int testCount = 0;
   int failCount = 0;

   iter_shifter #(.N(32), .STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .shamt(shamt), .din(din),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present one operand for a single accept edge, then drop in_valid.
   task automatic applyStimulus(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
      @(negedge clk);
      op = o; shamt = s; din = d; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic waitResult(output int edges);
      edges = 0;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         #1 edges++;
      end
   endtask

   task automatic runOp(input string tag, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] expVal, input int expEdges);
      int edges;
      applyStimulus(o, s, d);
      waitResult(edges);
      checkOutput({tag, " valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, " dout"}, dout, expVal);
      checkOutput({tag, " latency"}, edges, expEdges);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checkOutput({tag, " handoff in_ready"}, {31'b0, in_ready}, 32'd1);
      checkOutput({tag, " handoff out_valid"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int edges;
      logic [31:0] held;

      // Reset state
      #12;
      checkOutput("reset dout", dout, 32'h0);
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Functional vectors: op 0 SLL, 1 SRL, 2 SRA, 3 ROTL
      runOp("sll31", 2'd0, 5'd31, 32'h0000_0001, 32'h8000_0000, 8);
      runOp("sra4",  2'd2, 5'd4,  32'h8000_0000, 32'hF800_0000, 1);
      runOp("srl4",  2'd1, 5'd4,  32'h8000_0000, 32'h0800_0000, 1);
      runOp("rotl1", 2'd3, 5'd1,  32'h8000_0001, 32'h0000_0003, 1);
      runOp("sra0",  2'd2, 5'd0,  32'h8000_00F0, 32'h8000_00F0, 1);
      runOp("rotl0", 2'd3, 5'd0,  32'h1234_5678, 32'h1234_5678, 1);
      runOp("rotl8", 2'd3, 5'd8,  32'h1234_5678, 32'h3456_7812, 2);
      runOp("rotl31",2'd3, 5'd31, 32'h8000_0001, 32'hC000_0000, 8);
      runOp("sra31", 2'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 8);
      runOp("srapos",2'd2, 5'd5,  32'h7FFF_FFFF, 32'h03FF_FFFF, 2);
      runOp("sll5",  2'd0, 5'd5,  32'hDEAD_BEEF, 32'hD5B7_DDE0, 2);

      // Backpressure: result held while out_ready low, new requests ignored
      applyStimulus(2'd1, 5'd4, 32'h0000_00F0);
      waitResult(edges);
      checkOutput("bp dout", dout, 32'h0000_000F);
      @(negedge clk);
      in_valid = 1'b1; din = 32'hAAAA_AAAA; shamt = 5'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp hold valid", {31'b0, out_valid}, 32'd1);
         checkOutput("bp hold dout", dout, 32'h0000_000F);
         checkOutput("bp hold in_ready", {31'b0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checkOutput("bp release in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("bp release busy", {31'b0, busy}, 32'd0);

      // Flush during the third BUSY cycle of a 20-position shift
      applyStimulus(2'd0, 5'd20, 32'h0000_0001);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      checkOutput("flush in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("flush dout kept", dout, 32'h0000_000F);
      held = 32'd0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 if (out_valid) held = 32'd1;
      end
      checkOutput("flush no result", held, 32'd0);
      runOp("post flush srl8", 2'd1, 5'd8, 32'hFFFF_FFFF, 32'h00FF_FFFF, 2);

      // Flush and in_valid together in IDLE: nothing accepted
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; shamt = 5'd3;
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0;
      checkOutput("flush vs accept", {31'b0, busy}, 32'd0);

      // Flush beats out_ready in DONE: result discarded, dout retained
      applyStimulus(2'd0, 5'd4, 32'h0000_0001);
      waitResult(edges);
      @(negedge clk);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0; out_ready = 1'b0;
      checkOutput("flush done valid", {31'b0, out_valid}, 32'd0);
      checkOutput("flush done dout", dout, 32'h0000_0010);

      // Asynchronous reset between edges mid-BUSY
      applyStimulus(2'd0, 5'd31, 32'h0000_0001);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async rst out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("async rst dout", dout, 32'h0);
      checkOutput("async rst busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("after rst in_ready", {31'b0, in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
